key_press_gen: RTL and testbench
================================

# key_press_gen

Programmable key-press generator for unattended self-test of the interval-timing game. It emits the active-low START/STOP button waveforms that the timing game reads from KEY inputs. The interval between the START press and the STOP press is set by a target in seconds plus a signed 10 ms offset. It sits beside the game, with its START_N/STOP_N outputs ANDed onto the physical key lines.

## Interface
Parameters:
- CNT_10MSEC, 500000: CLK cycles per 10 ms tick (50 MHz).
- TICKS_PER_SEC, 100: ticks per second.
- LEAD_SEC, 3: fixed lead-in seconds added to every interval, covering the game's LED countdown.
- PRESS_10MS, 10: key-held width in ticks, ≥1.
- GAP_10MS, 50: ticks between STOP release and the acknowledge press, ≥1.

Ports:
- CLK in 1: system clock, 50 MHz; the only clock.
- RST in 1: synchronous, active-high reset.
- GO in 1: level; sampled only in IDLE; starts a sequence.
- ABORT in 1: level; returns to IDLE from any state.
- TARGET in 4: target seconds, 0–15; latched on GO.
- OFFSET in 8: signed two's-complement tick offset, −128..+127; latched on GO.
- ACK_EN in 1: latched on GO; when set, an extra STOP press clears the game's result screen.
- START_N out 1: emulated START key, active-low.
- STOP_N out 1: emulated STOP key, active-low.
- BUSY out 1: sequence in progress.
- DONE out 1: one-cycle completion pulse.
- STATE out 3: current state encoding, for LEDG debug.

## Operation
States and encodings: IDLE=0, START_PRESS=1, WAIT=2, STOP_PRESS=3, GAP=4, ACK_PRESS=5, FINISH=6.

Interval arithmetic:
- D = (LEAD_SEC + TARGET) × TICKS_PER_SEC + sext(OFFSET).
- Computed in 16-bit signed at GO.
- If D < PRESS_10MS + 1, D is clamped to PRESS_10MS + 1, so START is always released before STOP is pressed.

Tick counter:
- Counts 0..CNT_10MSEC−1.
- A tick is the cycle the counter equals CNT_10MSEC−1.
- Cleared on every state entry.
- The interval counter (16 bit) counts ticks since START_N fell.

Transitions:
- IDLE: GO=1 latches TARGET, OFFSET, ACK_EN and D, then goes to START_PRESS.
- START_PRESS: on the PRESS_10MS-th tick, go to WAIT.
- WAIT: when the interval count reaches D ticks, go to STOP_PRESS.
- STOP_PRESS: after PRESS_10MS ticks, go to GAP if ACK_EN, else FINISH.
- GAP: after GAP_10MS ticks, go to ACK_PRESS.
- ACK_PRESS: after PRESS_10MS ticks, go to FINISH.
- FINISH: one cycle, then IDLE.

Outputs (all registered):
- START_N=0 only in START_PRESS.
- STOP_N=0 only in STOP_PRESS and ACK_PRESS.
- BUSY=1 in every state except IDLE.
- DONE=1 only in FINISH.

Boundary conditions:
- GO held high at FINISH→IDLE starts a new sequence on the first IDLE cycle.
- GO while busy is ignored; TARGET/OFFSET changes while busy are ignored.
- ABORT, or ABORT together with GO: go to IDLE next cycle, both keys released, no DONE.
- RST overrides ABORT and GO.
- RST mid-sequence: next cycle all outputs are at reset values.

Reset values: START_N=1, STOP_N=1, BUSY=0, DONE=0, STATE=0, all counters 0.

## Timing
- GO sampled at edge t: START_N falls, BUSY rises, STATE=1 at t+1.
- START_N low for exactly PRESS_10MS×CNT_10MSEC cycles.
- STOP_N falls exactly D×CNT_10MSEC cycles after START_N falls, ±0 cycles.
- STOP_N low for exactly PRESS_10MS×CNT_10MSEC cycles.
- Acknowledge press begins GAP_10MS×CNT_10MSEC cycles after STOP_N rises.
- DONE asserts the cycle after the last key release; BUSY falls one cycle after DONE.
- ABORT at edge t: keys high and BUSY=0 at t+1.

## Test plan
Bench parameters for all scenarios: CNT_10MSEC=4, TICKS_PER_SEC=10, LEAD_SEC=3, PRESS_10MS=2, GAP_10MS=3.

1. TARGET=2, OFFSET=0, ACK_EN=0 -> START_N low 8 cycles; STOP_N falls 200 cycles after START_N falls; STOP_N low 8 cycles; DONE one cycle later; BUSY low next cycle.
2. TARGET=2, OFFSET=−5 (0xFB) -> interval 180 cycles. TARGET=15, OFFSET=+127 -> D=307 ticks, interval 1228 cycles.
3. TARGET=0, OFFSET=−128 -> D clamped to 3 ticks; STOP_N falls 12 cycles after START_N falls, 4 cycles after START_N rises.
4. ACK_EN=1, TARGET=1 -> second STOP_N low pulse of 8 cycles starting 12 cycles after the first release; DONE after it; STATE sequence 1,2,3,4,5,6,0.
5. ABORT during WAIT -> IDLE next cycle, both keys high, no DONE. GO pulsed during WAIT -> ignored, interval unchanged.
6. RST asserted in STOP_PRESS -> STOP_N=1, BUSY=0, STATE=0 next cycle. GO held across FINISH -> back-to-back sequences, START_N falls two cycles after DONE.

Source files
------------

// File: rtl/key_press_gen.sv
// rtl/key_press_gen.sv - programmable START/STOP key-press generator for timing-game self-test
// Emits active-low key waveforms spaced by a latched interval of (LEAD+TARGET)*TPS+OFFSET ticks.
module key_press_gen #(
  parameter int CNT_10MSEC    = 500000,
  parameter int TICKS_PER_SEC = 100,
  parameter int LEAD_SEC      = 3,
  parameter int PRESS_10MS    = 10,
  parameter int GAP_10MS      = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GO,
  input  logic       ABORT,
  input  logic [3:0] TARGET,
  input  logic [7:0] OFFSET,
  input  logic       ACK_EN,
  output logic       START_N,
  output logic       STOP_N,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_PRESS = 3'd1,
    WAIT        = 3'd2,
    STOP_PRESS  = 3'd3,
    GAP         = 3'd4,
    ACK_PRESS   = 3'd5,
    FINISH      = 3'd6
  } state_t;

  localparam int CW = $clog2(CNT_10MSEC + 1);
  localparam logic signed [15:0] D_MIN = 16'(PRESS_10MS + 1);

  state_t             state, next_state;
  logic [CW-1:0]      div_cnt;
  logic [15:0]        tick_cnt;
  logic [15:0]        ival_cnt;
  logic [15:0]        d_lat;
  logic               ack_lat;
  logic               tick;
  logic               press_done;
  logic               gap_done;
  logic signed [15:0] d_raw;
  logic signed [15:0] d_calc;

  // Clamp keeps STOP strictly after START has been released.
  always_comb begin
    d_raw  = 16'(LEAD_SEC * TICKS_PER_SEC) + 16'(int'(TARGET) * TICKS_PER_SEC)
           + {{8{OFFSET[7]}}, OFFSET};
    d_calc = (d_raw < D_MIN) ? D_MIN : d_raw;
  end

  assign tick       = (div_cnt == CW'(CNT_10MSEC - 1));
  assign press_done = tick && (tick_cnt == 16'(PRESS_10MS - 1));
  assign gap_done   = tick && (tick_cnt == 16'(GAP_10MS - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (GO) next_state = START_PRESS;
      START_PRESS: if (press_done) next_state = WAIT;
      WAIT:        if (tick && (ival_cnt + 16'd1 == d_lat)) next_state = STOP_PRESS;
      STOP_PRESS:  if (press_done) next_state = ack_lat ? GAP : FINISH;
      GAP:         if (gap_done) next_state = ACK_PRESS;
      ACK_PRESS:   if (press_done) next_state = FINISH;
      FINISH:      next_state = IDLE;
      default:     next_state = IDLE;
    endcase
    if (ABORT) next_state = IDLE;
  end

  // Tick divider and per-state tick count restart on every state change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      ival_cnt <= '0;
      d_lat    <= '0;
      ack_lat  <= 1'b0;
    end else begin
      if (next_state != state) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) tick_cnt <= tick_cnt + 16'd1;
      end
      if (state == IDLE && next_state == START_PRESS) begin
        d_lat    <= d_calc;
        ack_lat  <= ACK_EN;
        ival_cnt <= '0;
      end else if ((state == START_PRESS || state == WAIT) && tick) begin
        ival_cnt <= ival_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      START_N <= 1'b1;
      STOP_N  <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      STATE   <= 3'd0;
    end else begin
      START_N <= (next_state != START_PRESS);
      STOP_N  <= !(next_state == STOP_PRESS || next_state == ACK_PRESS);
      BUSY    <= (next_state != IDLE);
      DONE    <= (next_state == FINISH);
      STATE   <= next_state;
    end
  end

endmodule

// File: tb/tb_key_press_gen.sv
// tb/tb_key_press_gen.sv - scoreboard bench for key_press_gen with random sequences
// Stimulus pushes per-sequence expectations; a negedge monitor measures key edges and pops on DONE.
module tb_key_press_gen;
  localparam int CNT = 4, TPS = 10, LEAD = 3, PRESS = 2, GAP = 3;

  logic       CLK = 1'b0, RST = 1'b1, GO = 1'b0, ABORT = 1'b0, ACK_EN = 1'b0;
  logic [3:0] TARGET = 4'd0;
  logic [7:0] OFFSET = 8'd0;
  logic       START_N, STOP_N, BUSY, DONE;
  logic [2:0] STATE;

  key_press_gen #(
    .CNT_10MSEC(CNT), .TICKS_PER_SEC(TPS), .LEAD_SEC(LEAD),
    .PRESS_10MS(PRESS), .GAP_10MS(GAP)
  ) dut (
    .CLK(CLK), .RST(RST), .GO(GO), .ABORT(ABORT), .TARGET(TARGET), .OFFSET(OFFSET),
    .ACK_EN(ACK_EN), .START_N(START_N), .STOP_N(STOP_N), .BUSY(BUSY), .DONE(DONE),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct { int d; bit ack; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  // Interval in ticks from the behavioural rule, with the minimum enforced.
  function automatic int model_d(int t, int off);
    int d;
    d = (LEAD + t) * TPS + off;
    return (d < PRESS + 1) ? PRESS + 1 : d;
  endfunction

  int          cyc = 0, t_sf = 0, t_sr = 0, t_f1 = 0, t_r1 = 0, t_f2 = 0, t_r2 = 0, nstop = 0;
  logic [31:0] seq = 0;
  bit          prev_start = 1'b1, prev_stop = 1'b1, busy_chk = 1'b0;
  logic [2:0]  prev_state = 3'd0;
  exp_t        e;

  always @(negedge CLK) begin
    cyc++;
    if (prev_start && !START_N) begin
      t_sf = cyc; nstop = 0; seq = 0;
    end
    if (!prev_start && START_N) t_sr = cyc;
    if (prev_stop && !STOP_N) begin
      nstop++;
      if (nstop == 1) t_f1 = cyc; else t_f2 = cyc;
    end
    if (!prev_stop && STOP_N) begin
      if (nstop == 1) t_r1 = cyc; else t_r2 = cyc;
    end
    if (STATE != prev_state && STATE != 3'd0) seq = {seq[27:0], 1'b0, STATE};
    if (busy_chk) begin
      chk("busy_after_done", int'(BUSY), 0);
      chk("state_after_done", int'(STATE), 0);
      busy_chk = 1'b0;
    end
    if (DONE === 1'b1) begin
      if (q.size() == 0) begin
        timeout("unexpected_done");
      end else begin
        e = q.pop_front();
        chk("start_width", t_sr - t_sf, PRESS * CNT);
        chk("interval", t_f1 - t_sf, e.d * CNT);
        chk("stop_width", t_r1 - t_f1, PRESS * CNT);
        chk("stop_pulses", nstop, e.ack ? 2 : 1);
        if (e.ack) begin
          chk("ack_gap", t_f2 - t_r1, GAP * CNT);
          chk("ack_width", t_r2 - t_f2, PRESS * CNT);
          chk("done_time", cyc, t_r2);
          chk("state_seq", int'(seq), 32'h123456);
        end else begin
          chk("done_time", cyc, t_r1);
          chk("state_seq", int'(seq), 32'h1236);
        end
        busy_chk = 1'b1;
      end
    end
    prev_start = START_N;
    prev_stop  = STOP_N;
    prev_state = STATE;
  end

  task automatic start_seq(int t, int off, bit ack, bit push);
    exp_t x;
    @(negedge CLK);
    TARGET = 4'(t); OFFSET = 8'(off); ACK_EN = ack; GO = 1'b1;
    if (push) begin
      x.d = model_d(t, off); x.ack = ack;
      q.push_back(x);
    end
    @(negedge CLK);
    GO = 1'b0;
    TARGET = 4'($urandom); OFFSET = 8'($urandom); ACK_EN = 1'($urandom);
    if (push) begin
      chk("go_start_n", int'(START_N), 0);
      chk("go_state", int'(STATE), 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) timeout("wait_idle");
    @(negedge CLK);
  endtask

  task automatic wait_state(int s);
    int n = 0;
    while (int'(STATE) != s && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) timeout("wait_state");
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_start_n", int'(START_N), 1);
    chk("rst_stop_n", int'(STOP_N), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_state", int'(STATE), 0);
    RST = 1'b0;

    start_seq(2, 0, 0, 1);     wait_idle();
    start_seq(2, -5, 0, 1);    wait_idle();
    start_seq(15, 127, 0, 1);  wait_idle();
    start_seq(0, -128, 0, 1);  wait_idle();
    start_seq(1, 0, 1, 1);     wait_idle();

    for (int i = 0; i < 8; i++) begin
      start_seq($urandom_range(0, 15), int'($urandom_range(0, 255)) - 128,
                1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 1) == 1) begin
        wait_state(2);
        repeat ($urandom_range(0, 5)) @(negedge CLK);
        GO = 1'b1; TARGET = 4'($urandom); OFFSET = 8'($urandom);
        @(negedge CLK);
        GO = 1'b0;
      end
      wait_idle();
    end

    // Abort (together with GO) in WAIT: no DONE may follow.
    start_seq(2, 0, 0, 0);
    wait_state(2);
    repeat (20) @(negedge CLK);
    ABORT = 1'b1; GO = 1'b1;
    @(posedge CLK); #1;
    chk("abort_start_n", int'(START_N), 1);
    chk("abort_stop_n", int'(STOP_N), 1);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_state", int'(STATE), 0);
    @(negedge CLK);
    ABORT = 1'b0; GO = 1'b0;
    repeat (300) @(negedge CLK);
    chk("abort_stays_idle", int'(BUSY), 0);

    start_seq(0, 0, 1, 0);
    wait_state(3);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mid_stop_n", int'(STOP_N), 1);
    chk("rst_mid_busy", int'(BUSY), 0);
    chk("rst_mid_state", int'(STATE), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // GO held across FINISH gives back-to-back sequences.
    TARGET = 4'd0; OFFSET = 8'd0; ACK_EN = 1'b0; GO = 1'b1;
    q.push_back('{d: model_d(0, 0), ack: 1'b0});
    q.push_back('{d: model_d(0, 0), ack: 1'b0});
    n = 0;
    while (DONE !== 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) timeout("b2b_done");
    n = 0;
    while (START_N !== 1'b0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b_start_gap", n, 2);
    GO = 1'b0;
    wait_idle();

    repeat (5) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
